// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the matrix coprocessor control path.
// Holds default bus widths (shared with the ALU and top level), opcode
// encodings, opcode classification helpers and the sequencer state enum.
package matrix_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 256;

  localparam logic [2:0] OP_ADD       = 3'd0;
  localparam logic [2:0] OP_SUB       = 3'd1;
  localparam logic [2:0] OP_TRANSPOSE = 3'd2;
  localparam logic [2:0] OP_NEG       = 3'd3;
  localparam logic [2:0] OP_SCALE2    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_A,
    S_WAIT_B,
    S_EXEC,
    S_WAIT_ALU,
    S_WR_C,
    S_DONE
  } state_t;

  function automatic logic is_valid(input logic [2:0] op);
    return op <= OP_SCALE2;
  endfunction

  function automatic logic is_unary(input logic [2:0] op);
    return (op == OP_TRANSPOSE) || (op == OP_NEG);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: timing helper for the matrix sequencer.
// A loadable down-counter measures RAM read latency; an up-counter measures
// how long the ALU has been busy. One expire flag reports whichever is active.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   load          load the latency down-counter with RD_LAT
//   clr           clear the timeout up-counter
//   run_up        timeout counting active (also selects which count expires)
//   expire        read latency elapsed / ALU timeout reached
module seq_timer #(
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic run_up,
  output logic expire
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [2:0]      down;
  logic [TO_W-1:0] up;

  always_ff @(posedge clk) begin
    if (!rst) begin
      down <= '0;
      up   <= '0;
    end else begin
      if (load)
        down <= 3'(RD_LAT);
      else if (down != 3'd0)
        down <= down - 3'd1;

      if (clr)
        up <= '0;
      else if (run_up && (up != TO_W'(TIMEOUT)))
        up <= up + 1'b1;
    end
  end

  // Flags on the last cycle so the owner acts on the edge where the count
  // would land: down reaches 0, or up reaches TIMEOUT.
  assign expire = run_up ? (up == TO_W'(TIMEOUT - 1)) : (down == 3'd1);

endmodule

// File: rtl/matrix_op_sequencer.sv
// matrix_op_sequencer: runs one matrix operation end to end. Reads operand A
// (and B for binary ops) from the single-port matrix RAM, hands them to the
// ALU under a start/done handshake and writes the result back.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start, op_code           command strobe (IDLE only) and operation
//   addr_a, addr_b, addr_c   operand and result addresses
//   busy, done, err, ovf     status: in progress, completion pulse, sticky flags
//   ram_addr/we/wdata/rdata  matrix RAM port, owned for the whole operation
//   alu_a/b/op, alu_start    registered ALU operands and start pulse
//   alu_done/result/ovf      ALU response
//
// state      | meaning
// -----------+------------------------------------------------
// S_IDLE     | waiting for start, RAM address parked at 0
// S_WAIT_A   | reading operand A, waiting RD_LAT cycles
// S_WAIT_B   | reading operand B (binary ops only)
// S_EXEC     | one-cycle alu_start pulse
// S_WAIT_ALU | waiting for alu_done, timeout counter running
// S_WR_C     | one-cycle write of the result to addr_c
// S_DONE     | one-cycle done pulse
module matrix_op_sequencer
  import matrix_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_c,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] a_q, b_q, c_q;
  logic              expire;
  logic              accept;
  logic              tmr_load;

  assign accept   = (state == S_IDLE) && start;
  assign tmr_load = (accept && is_valid(op_code)) ||
                    ((state == S_WAIT_A) && expire && !is_unary(alu_op));

  seq_timer #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .clr    (state == S_EXEC),
    .run_up (state == S_WAIT_ALU),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (start) state_n = is_valid(op_code) ? S_WAIT_A : S_DONE;
      S_WAIT_A:   if (expire) state_n = is_unary(alu_op) ? S_EXEC : S_WAIT_B;
      S_WAIT_B:   if (expire) state_n = S_EXEC;
      S_EXEC:     state_n = S_WAIT_ALU;
      S_WAIT_ALU: begin
        if (alu_done)    state_n = S_WR_C;
        else if (expire) state_n = S_DONE;
      end
      S_WR_C:     state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      ram_wdata <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_q    <= addr_a;
          b_q    <= addr_b;
          c_q    <= addr_c;
          alu_op <= op_code;
          alu_b  <= '0;  // unary ops never load B
          err    <= !is_valid(op_code);
          ovf    <= 1'b0;
        end
        S_WAIT_A: if (expire) alu_a <= ram_rdata;
        S_WAIT_B: if (expire) alu_b <= ram_rdata;
        S_WAIT_ALU: begin
          if (alu_done) begin
            ram_wdata <= alu_result;
            ovf       <= alu_ovf;
          end else if (expire) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are gated by rst so a reset asserted mid-write drops the write
  // in the same cycle instead of one edge later.
  assign busy      = rst && (state != S_IDLE);
  assign done      = rst && (state == S_DONE);
  assign ram_we    = rst && (state == S_WR_C);
  assign alu_start = rst && (state == S_EXEC);

  always_comb begin
    ram_addr = '0;
    if (rst) begin
      case (state)
        S_WAIT_A: ram_addr = a_q;
        S_WAIT_B: ram_addr = b_q;
        S_WR_C:   ram_addr = c_q;
        default:  ram_addr = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
module tb_matrix_op_sequencer;

  localparam logic [255:0] POISON = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] MA     = {8{32'hA0A0_0001}};
  localparam logic [255:0] MB     = {8{32'hB0B0_0002}};
  localparam logic [255:0] MT     = {8{32'h7777_0010}};
  localparam logic [255:0] RES1   = {8{32'h1111_2222}};
  localparam logic [255:0] RES2   = {8{32'h3333_4444}};
  localparam logic [255:0] RES3   = {8{32'h5555_6666}};
  localparam logic [255:0] RES4   = {8{32'h9999_AAAA}};

  logic         clk, rst, start;
  logic [2:0]   op_code;
  logic [7:0]   addr_a, addr_b, addr_c;
  logic         busy, done, err, ovf;
  logic [7:0]   ram_addr;
  logic         ram_we;
  logic [255:0] ram_wdata, ram_rdata;
  logic [255:0] alu_a, alu_b;
  logic [2:0]   alu_op;
  logic         alu_start, alu_done, alu_ovf;
  logic [255:0] alu_result;

  matrix_op_sequencer #(.ADDR_W(8), .DATA_W(256), .RD_LAT(2), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .busy(busy), .done(done), .err(err), .ovf(ovf),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [255:0] mem [0:255];
  logic         prev_busy;
  logic [7:0]   prev_addr;

  int           r_done_cyc, r_start_cyc, r_start_cnt, r_we_cnt, r_we_cyc;
  logic [7:0]   r_we_addr, r_addr1;
  logic [255:0] r_we_data, r_alu_a, r_alu_b;
  logic [2:0]   r_alu_op;
  logic         r_err, r_ovf, r_busy_after, r_busy1;

  // Drives one command from a negedge and follows it to the cycle after done.
  // Cycle k is the clock period following edge k-1 (start sampled at edge 0).
  // RAM model: data is valid only once the address has been stable and busy
  // for a full previous cycle, so an early capture sees POISON.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input int alu_n, input logic ovf_in,
                         input logic restart, input logic [255:0] res);
    r_done_cyc = -1; r_start_cyc = -1; r_start_cnt = 0; r_we_cnt = 0; r_we_cyc = -1;
    r_we_addr = '0; r_we_data = '0; r_alu_a = '0; r_alu_b = '0; r_alu_op = '0;
    r_err = 1'bx; r_ovf = 1'bx; r_busy_after = 1'bx; r_addr1 = 'x; r_busy1 = 1'bx;
    op_code = op; addr_a = a; addr_b = b; addr_c = c; alu_result = res;
    prev_busy = 1'b0; ram_rdata = POISON; start = 1'b1;
    for (int cyc = 1; cyc <= 700; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin r_addr1 = ram_addr; r_busy1 = busy; end
      if (alu_start) begin
        r_start_cnt++;
        if (r_start_cyc < 0) r_start_cyc = cyc;
        r_alu_a = alu_a; r_alu_b = alu_b; r_alu_op = alu_op;
      end
      if (ram_we) begin
        r_we_cnt++; r_we_cyc = cyc; r_we_addr = ram_addr; r_we_data = ram_wdata;
        mem[ram_addr] = ram_wdata;
      end
      if (r_done_cyc >= 0) begin r_busy_after = busy; break; end
      if (done) begin r_done_cyc = cyc; r_err = err; r_ovf = ovf; end
      alu_done = 1'b0; alu_ovf = 1'b0;
      if (alu_n > 0 && r_start_cyc > 0 && cyc == r_start_cyc + alu_n) begin
        alu_done = 1'b1; alu_ovf = ovf_in;
      end
      if (restart && r_start_cyc > 0 && cyc == r_start_cyc + 1) begin
        start = 1'b1; op_code = 3'd6; addr_c = 8'h55;
      end
      ram_rdata = (prev_busy && prev_addr == ram_addr) ? mem[ram_addr] : POISON;
      prev_busy = busy; prev_addr = ram_addr;
    end
    start = 1'b0; alu_done = 1'b0; alu_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, err, ovf, ram_we, alu_start} !== 6'b0) begin errors++;
      $display("FAIL reset_flags: got %b want 000000", {busy, done, err, ovf, ram_we, alu_start}); end
    checks++; if (ram_addr !== 8'h00 || alu_op !== 3'd0) begin errors++;
      $display("FAIL reset_addr_op: got addr %h op %0d want 0 0", ram_addr, alu_op); end
    checks++; if (ram_wdata !== '0 || alu_a !== '0 || alu_b !== '0) begin errors++;
      $display("FAIL reset_data: got nonzero data, want all 0"); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    run_cmd(3'd0, 8'h00, 8'h01, 8'h02, 1, 1'b0, 1'b0, RES1);
    checks++; if (r_busy1 !== 1'b1 || r_addr1 !== 8'h00) begin errors++;
      $display("FAIL add_cycle1: got busy %b addr %h want 1 00", r_busy1, r_addr1); end
    checks++; if (r_start_cyc !== 5 || r_start_cnt !== 1) begin errors++;
      $display("FAIL add_alu_start: got cycle %0d count %0d want 5 1", r_start_cyc, r_start_cnt); end
    checks++; if (r_alu_a !== MA || r_alu_b !== MB || r_alu_op !== 3'd0) begin errors++;
      $display("FAIL add_operands: got a %h b %h op %0d", r_alu_a, r_alu_b, r_alu_op); end
    checks++; if (r_we_cnt !== 1 || r_we_cyc !== 7 || r_we_addr !== 8'h02) begin errors++;
      $display("FAIL add_write: got count %0d cycle %0d addr %h want 1 7 02", r_we_cnt, r_we_cyc, r_we_addr); end
    checks++; if (r_we_data !== RES1) begin errors++;
      $display("FAIL add_wdata: got %h want %h", r_we_data, RES1); end
    checks++; if (r_done_cyc !== 8 || r_err !== 1'b0) begin errors++;
      $display("FAIL add_done: got cycle %0d err %b want 8 0", r_done_cyc, r_err); end
    checks++; if (r_busy_after !== 1'b0) begin errors++;
      $display("FAIL add_busy_drop: got %b want 0", r_busy_after); end
  endtask

  task automatic test_transpose();
    run_cmd(3'd2, 8'h10, 8'h01, 8'h10, 1, 1'b0, 1'b0, RES2);
    checks++; if (r_alu_a !== MT || r_alu_b !== '0 || r_alu_op !== 3'd2) begin errors++;
      $display("FAIL tr_operands: got a %h b %h op %0d", r_alu_a, r_alu_b, r_alu_op); end
    checks++; if (r_start_cyc !== 3) begin errors++;
      $display("FAIL tr_alu_start: got %0d want 3", r_start_cyc); end
    checks++; if (r_we_cnt !== 1 || r_we_cyc !== 5 || r_we_addr !== 8'h10) begin errors++;
      $display("FAIL tr_write: got count %0d cycle %0d addr %h want 1 5 10", r_we_cnt, r_we_cyc, r_we_addr); end
    checks++; if (r_done_cyc !== 6 || r_err !== 1'b0) begin errors++;
      $display("FAIL tr_done: got cycle %0d err %b want 6 0", r_done_cyc, r_err); end
    checks++; if (mem[8'h10] !== RES2) begin errors++;
      $display("FAIL tr_mem: got %h want %h", mem[8'h10], RES2); end
  endtask

  task automatic test_invalid();
    run_cmd(3'd6, 8'h00, 8'h01, 8'h20, 1, 1'b0, 1'b0, RES1);
    checks++; if (r_done_cyc !== 1 || r_err !== 1'b1) begin errors++;
      $display("FAIL inv_done: got cycle %0d err %b want 1 1", r_done_cyc, r_err); end
    checks++; if (r_we_cnt !== 0 || r_start_cnt !== 0) begin errors++;
      $display("FAIL inv_side_effects: got writes %0d starts %0d want 0 0", r_we_cnt, r_start_cnt); end
    checks++; if (r_busy_after !== 1'b0) begin errors++;
      $display("FAIL inv_busy_drop: got %b want 0", r_busy_after); end
  endtask

  task automatic test_timeout();
    mem[8'h04] = MT;
    run_cmd(3'd0, 8'h00, 8'h01, 8'h04, 0, 1'b0, 1'b0, RES1);
    checks++; if (r_done_cyc !== 261 || r_err !== 1'b1) begin errors++;
      $display("FAIL to_done: got cycle %0d err %b want 261 1", r_done_cyc, r_err); end
    checks++; if (r_we_cnt !== 0 || mem[8'h04] !== MT) begin errors++;
      $display("FAIL to_no_write: got writes %0d want 0", r_we_cnt); end
  endtask

  task automatic test_restart_ovf();
    run_cmd(3'd0, 8'h00, 8'h01, 8'h03, 1, 1'b1, 1'b1, RES3);
    checks++; if (r_done_cyc !== 8 || r_err !== 1'b0 || r_ovf !== 1'b1) begin errors++;
      $display("FAIL rs_done: got cycle %0d err %b ovf %b want 8 0 1", r_done_cyc, r_err, r_ovf); end
    checks++; if (r_we_cnt !== 1 || r_we_addr !== 8'h03) begin errors++;
      $display("FAIL rs_write: got count %0d addr %h want 1 03", r_we_cnt, r_we_addr); end
    checks++; if (r_busy_after !== 1'b0) begin errors++;
      $display("FAIL rs_not_queued: got busy %b want 0", r_busy_after); end
  endtask

  task automatic test_back_to_back();
    run_cmd(3'd3, 8'h01, 8'h00, 8'h05, 2, 1'b0, 1'b0, RES2);
    checks++; if (r_busy1 !== 1'b1 || r_addr1 !== 8'h01) begin errors++;
      $display("FAIL b2b_accept: got busy %b addr %h want 1 01", r_busy1, r_addr1); end
    checks++; if (r_done_cyc !== 7 || r_ovf !== 1'b0 || r_alu_op !== 3'd3) begin errors++;
      $display("FAIL b2b_done: got cycle %0d ovf %b op %0d want 7 0 3", r_done_cyc, r_ovf, r_alu_op); end
    checks++; if (r_alu_a !== MB || r_alu_b !== '0) begin errors++;
      $display("FAIL b2b_operands: got a %h b %h", r_alu_a, r_alu_b); end
  endtask

  task automatic test_reset_in_wr();
    logic got;
    int   st;
    got = 1'b0; st = -1;
    op_code = 3'd0; addr_a = 8'h00; addr_b = 8'h01; addr_c = 8'h06;
    alu_result = RES4; prev_busy = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = 1'b0; alu_done = 1'b0;
      if (alu_start) st = cyc;
      if (st > 0 && cyc == st + 1) alu_done = 1'b1;
      if (ram_we) begin
        got = 1'b1; rst = 1'b0; #1;
        checks++; if (ram_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++;
          $display("FAIL rw_immediate: got we %b done %b busy %b want 0 0 0", ram_we, done, busy); end
        break;
      end
      ram_rdata = (prev_busy && prev_addr == ram_addr) ? mem[ram_addr] : POISON;
      prev_busy = busy; prev_addr = ram_addr;
    end
    alu_done = 1'b0;
    checks++; if (got !== 1'b1) begin errors++;
      $display("FAIL rw_reach_wr: got %b want 1 (WR_C never seen)", got); end
    @(negedge clk);
    checks++; if ({busy, done, err, ovf, ram_we, alu_start} !== 6'b0 || ram_addr !== 8'h00 || alu_op !== 3'd0) begin errors++;
      $display("FAIL rw_flags: got %b addr %h op %0d", {busy, done, err, ovf, ram_we, alu_start}, ram_addr, alu_op); end
    checks++; if (ram_wdata !== '0 || alu_a !== '0 || alu_b !== '0) begin errors++;
      $display("FAIL rw_data: got nonzero data, want all 0"); end
    rst = 1'b1;
    @(negedge clk);
    run_cmd(3'd1, 8'h00, 8'h01, 8'h07, 1, 1'b0, 1'b0, RES4);
    checks++; if (r_done_cyc !== 8 || r_err !== 1'b0 || r_we_addr !== 8'h07 || r_we_cnt !== 1) begin errors++;
      $display("FAIL rw_rerun: got done %0d err %b addr %h writes %0d", r_done_cyc, r_err, r_we_addr, r_we_cnt); end
    checks++; if (mem[8'h07] !== RES4 || r_alu_op !== 3'd1) begin errors++;
      $display("FAIL rw_rerun_data: got %h op %0d", mem[8'h07], r_alu_op); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op_code = '0; addr_a = '0; addr_b = '0; addr_c = '0;
    ram_rdata = POISON; alu_done = 1'b0; alu_ovf = 1'b0; alu_result = '0;
    prev_addr = '0; prev_busy = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = MA; mem[8'h01] = MB; mem[8'h10] = MT;
    @(negedge clk);
    test_reset();
    test_add();
    test_transpose();
    test_invalid();
    test_timeout();
    test_restart_ovf();
    test_back_to_back();
    test_reset_in_wr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
